seg_display_ctrl: RTL

Parametrised seven-segment display controller, next generation of the board display driver. Accepts a binary value through a valid/busy handshake and converts it sequentially to hex or decimal digits, with signed mode, overflow indication and optional leading-zero suppression. It then time-multiplexes a DIGITS-wide common-anode tube array and produces the blink strobe. It sits between the CPU MMIO display register and the board pins.

---
 rtl/seg_pkg.sv | 56 +++++
 rtl/bin2bcd_seq.sv | 96 +++++++++
 rtl/seg_display_ctrl.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// ---------------------------------------------------------------------------
// seg_pkg
// Shared types and helpers for the seven-segment display controller.
//   glyph_t       5-bit glyph code: 0-15 hex characters, 16 dash, 17 blank
//   bcd_state_t   state of the sequential binary-to-BCD converter
//   ctl_state_t   state of the load/convert control FSM in the top level
//   seg_encode()  glyph code -> active-high {g,f,e,d,c,b,a}
// ---------------------------------------------------------------------------
package seg_pkg;

  typedef logic [4:0] glyph_t;

  localparam glyph_t GLYPH_ZERO  = 5'd0;
  localparam glyph_t GLYPH_DASH  = 5'd16;
  localparam glyph_t GLYPH_BLANK = 5'd17;

  typedef enum logic [1:0] {
    BCD_IDLE  = 2'd0,
    BCD_SHIFT = 2'd1,
    BCD_DONE  = 2'd2
  } bcd_state_t;

  typedef enum logic [1:0] {
    CTL_IDLE = 2'd0,
    CTL_HEX  = 2'd1,
    CTL_DEC  = 2'd2
  } ctl_state_t;

  // Active-high segment pattern, bit order {g,f,e,d,c,b,a}.
  // Unknown codes (18-31) render as blank.
  function automatic logic [6:0] seg_encode(input glyph_t g);
    logic [6:0] s;
    case (g)
      5'd0:    s = 7'h3F;
      5'd1:    s = 7'h06;
      5'd2:    s = 7'h5B;
      5'd3:    s = 7'h4F;
      5'd4:    s = 7'h66;
      5'd5:    s = 7'h6D;
      5'd6:    s = 7'h7D;
      5'd7:    s = 7'h07;
      5'd8:    s = 7'h7F;
      5'd9:    s = 7'h6F;
      5'd10:   s = 7'h77;
      5'd11:   s = 7'h7C;
      5'd12:   s = 7'h39;
      5'd13:   s = 7'h5E;
      5'd14:   s = 7'h79;
      5'd15:   s = 7'h71;
      5'd16:   s = 7'h40;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// ---------------------------------------------------------------------------
// bin2bcd_seq
// Iterative double-dabble converter: one input bit per cycle, MSB first,
// DATA_W shift cycles per conversion.
//   clk_i    clock
//   rst_ni   asynchronous active-low reset
//   start_i  load bin_i and begin (honoured only in BCD_IDLE)
//   bin_i    unsigned binary value
//   state_o  converter state; BCD_DONE marks the single cycle in which
//            bcd_o / ovf_o hold the finished result
//   bcd_o    DIGITS packed BCD digits, digit 0 in bits [3:0]
//   ovf_o    sticky: a 1 was shifted out of the top BCD digit
// ---------------------------------------------------------------------------
module bin2bcd_seq
  import seg_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DIGITS = 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  input  logic [DATA_W-1:0]   bin_i,
  output bcd_state_t          state_o,
  output logic [4*DIGITS-1:0] bcd_o,
  output logic                ovf_o
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  bcd_state_t         state_q;
  logic [DATA_W-1:0]  bin_q, bin_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d, adj;
  logic [CNT_W-1:0]   cnt_q;
  logic               ovf_q;
  logic               carry;

  // Add-3 to every digit that is 5 or more before the shift.
  always_comb begin
    adj = bcd_q;
    for (int d = 0; d < DIGITS; d++) begin
      if (adj[4*d +: 4] >= 4'd5) begin
        adj[4*d +: 4] = adj[4*d +: 4] + 4'd3;
      end
    end
  end

  assign bcd_d = {adj[BCD_W-2:0], bin_q[DATA_W-1]};
  assign bin_d = bin_q << 1;
  // The bit leaving the top digit means the value needs more than DIGITS digits.
  assign carry = adj[BCD_W-1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= BCD_IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        BCD_IDLE: begin
          if (start_i) begin
            bin_q   <= bin_i;
            bcd_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            state_q <= BCD_SHIFT;
          end
        end
        BCD_SHIFT: begin
          bin_q <= bin_d;
          bcd_q <= bcd_d;
          ovf_q <= ovf_q | carry;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_q <= BCD_DONE;
          end
        end
        BCD_DONE: begin
          state_q <= BCD_IDLE;
        end
        default: begin
          state_q <= BCD_IDLE;
        end
      endcase
    end
  end

  assign state_o = state_q;
  assign bcd_o   = bcd_q;
  assign ovf_o   = ovf_q;

endmodule

// File: rtl/seg_display_ctrl.sv
// ---------------------------------------------------------------------------
// seg_display_ctrl
// Loads a binary value, converts it to hex or decimal glyphs (signed decimal,
// overflow dashes, optional leading-zero blanking), then time-multiplexes a
// common-anode DIGITS-wide tube array and generates a blink strobe.
//
// Build option: SEG_LZ_SUPPRESS_EN
//   defined   -> leading zeros blank (digit 0 always shown), sign placed just
//                left of the highest nonzero digit
//   undefined -> all digits shown, decimal sign in digit DIGITS-1
//
// Ports
//   clk, rst_n     clock, asynchronous active-low reset
//   data_in        value to display
//   data_valid     load request
//   radix_hex      sampled with the load: 1 hex, 0 decimal
//   signed_mode    sampled with the load: two's complement (decimal only)
//   blink_en       enables blink_out
//   busy           conversion in progress
//   seg_en         digit enables, active-low, one-cold
//   seg_out        {dp,g,f,e,d,c,b,a}, active-low, dp always off
//   blink_out      blink square wave gated by blink_en
// ---------------------------------------------------------------------------
module seg_display_ctrl
  import seg_pkg::*;
#(
  parameter int DIGITS   = 8,
  parameter int DATA_W   = 32,
  parameter int CLK_HZ   = 100_000_000,
  parameter int SCAN_HZ  = 1000,
  parameter int BLINK_HZ = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  input  logic              radix_hex,
  input  logic              signed_mode,
  input  logic              blink_en,
  output logic              busy,
  output logic [DIGITS-1:0] seg_en,
  output logic [7:0]        seg_out,
  output logic              blink_out
);

  localparam int BCD_W      = 4 * DIGITS;
  localparam int EXT_W      = (DATA_W > BCD_W) ? DATA_W : BCD_W;
  localparam int PRESCALE   = (CLK_HZ / SCAN_HZ > 0) ? (CLK_HZ / SCAN_HZ) : 1;
  localparam int BLINK_HALF = (CLK_HZ / (2 * BLINK_HZ) > 0) ? (CLK_HZ / (2 * BLINK_HZ)) : 1;
  localparam int PS_W       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int BL_W       = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam int IDX_W      = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  // -------------------------------------------------------------------------
  // Handshake: a load is taken on any rising edge where data_valid=1 and
  // busy=0. busy rises on that edge and falls on the edge that commits the
  // new glyphs; data_valid seen while busy=1 is discarded, never queued.
  // -------------------------------------------------------------------------
  ctl_state_t        state_q;
  logic              busy_q;
  logic [DATA_W-1:0] data_q;
  logic              neg_q;
  glyph_t            buf_q [DIGITS];
  glyph_t            buf_d [DIGITS];
  glyph_t            glyph_d [DIGITS];

  logic              accept;
  logic              in_neg;
  logic [DATA_W-1:0] mag;
  logic              commit;

  bcd_state_t        bcd_state;
  logic [BCD_W-1:0]  bcd;
  logic              bcd_ovf;

  assign accept = data_valid && !busy_q;
  assign in_neg = !radix_hex && signed_mode && data_in[DATA_W-1];
  // Unsigned negate: the most-negative input yields its correct magnitude.
  assign mag    = in_neg ? ('0 - data_in) : data_in;

  bin2bcd_seq #(
    .DATA_W (DATA_W),
    .DIGITS (DIGITS)
  ) u_bin2bcd (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .start_i (accept && !radix_hex),
    .bin_i   (mag),
    .state_o (bcd_state),
    .bcd_o   (bcd),
    .ovf_o   (bcd_ovf)
  );

  // -------------------------------------------------------------------------
  // Digit source and glyph mapping
  // -------------------------------------------------------------------------
  logic [EXT_W-1:0] hex_ext;
  logic             hex_ovf;
  logic             hex_sel;
  logic [3:0]       src_dig [DIGITS];
  logic             src_ovf;

  assign hex_ext = EXT_W'(data_q);
  // Any set bit above the displayable nibbles; constant 0 when none exist.
  assign hex_ovf = |(hex_ext >> BCD_W);
  assign hex_sel = (state_q == CTL_HEX);

  always_comb begin
    for (int i = 0; i < DIGITS; i++) begin
      src_dig[i] = hex_sel ? hex_ext[4*i +: 4] : bcd[4*i +: 4];
    end
    // A negative value gives up the top digit to the sign.
    src_ovf = hex_sel ? hex_ovf
                      : (bcd_ovf | (neg_q & (bcd[BCD_W-1 -: 4] != 4'd0)));
  end

`ifdef SEG_LZ_SUPPRESS_EN
  logic [IDX_W-1:0] top_nz;

  always_comb begin
    top_nz = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (src_dig[i] != 4'd0) top_nz = IDX_W'(i);
    end
  end

  always_comb begin
    for (int i = 0; i < DIGITS; i++) begin
      if (src_ovf) begin
        glyph_d[i] = GLYPH_DASH;
      end else if (IDX_W'(i) <= top_nz) begin
        glyph_d[i] = {1'b0, src_dig[i]};
      end else if (neg_q && (i == int'(top_nz) + 1)) begin
        glyph_d[i] = GLYPH_DASH;
      end else begin
        glyph_d[i] = GLYPH_BLANK;
      end
    end
  end
`else
  always_comb begin
    for (int i = 0; i < DIGITS; i++) begin
      if (src_ovf) begin
        glyph_d[i] = GLYPH_DASH;
      end else if (neg_q && (i == DIGITS - 1)) begin
        glyph_d[i] = GLYPH_DASH;
      end else begin
        glyph_d[i] = {1'b0, src_dig[i]};
      end
    end
  end
`endif

  assign commit = (state_q == CTL_HEX) ||
                  ((state_q == CTL_DEC) && (bcd_state == BCD_DONE));

  // All digits switch together on the commit edge.
  always_comb begin
    for (int i = 0; i < DIGITS; i++) begin
      buf_d[i] = commit ? glyph_d[i] : buf_q[i];
    end
  end

  // -------------------------------------------------------------------------
  // Control FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CTL_IDLE;
      busy_q  <= 1'b0;
      data_q  <= '0;
      neg_q   <= 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
        buf_q[i] <= (i == 0) ? GLYPH_ZERO : GLYPH_BLANK;
      end
    end else begin
      buf_q <= buf_d;
      case (state_q)
        CTL_IDLE: begin
          if (accept) begin
            data_q  <= data_in;
            neg_q   <= in_neg;
            busy_q  <= 1'b1;
            state_q <= radix_hex ? CTL_HEX : CTL_DEC;
          end
        end
        CTL_HEX: begin
          busy_q  <= 1'b0;
          state_q <= CTL_IDLE;
        end
        CTL_DEC: begin
          if (bcd_state == BCD_DONE) begin
            busy_q  <= 1'b0;
            state_q <= CTL_IDLE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= CTL_IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;

  // -------------------------------------------------------------------------
  // Scan multiplexer
  // -------------------------------------------------------------------------
  logic [PS_W-1:0]   presc_q;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DIGITS-1:0] seg_en_q;
  logic [7:0]        seg_out_q;
  logic              tick;

  assign tick  = (presc_q == PS_W'(PRESCALE - 1));
  assign idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : (idx_q + 1'b1);

  // buf_d is used so a commit on the tick edge is shown immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q   <= '0;
      idx_q     <= '0;
      seg_en_q  <= '1;
      seg_out_q <= 8'hFF;
    end else if (tick) begin
      presc_q   <= '0;
      idx_q     <= idx_d;
      seg_en_q  <= ~(DIGITS'(1) << idx_d);
      seg_out_q <= {1'b1, ~seg_encode(buf_d[idx_d])};
    end else begin
      presc_q <= presc_q + 1'b1;
    end
  end

  assign seg_en  = seg_en_q;
  assign seg_out = seg_out_q;

  // -------------------------------------------------------------------------
  // Blink: the counter idles at 0 with the wave low, so the first enabled
  // edge toggles the wave high.
  // -------------------------------------------------------------------------
  logic [BL_W-1:0] bcnt_q;
  logic            blink_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt_q  <= '0;
      blink_q <= 1'b0;
    end else if (!blink_en) begin
      bcnt_q  <= '0;
      blink_q <= 1'b0;
    end else begin
      if (bcnt_q == '0) blink_q <= ~blink_q;
      bcnt_q <= (bcnt_q == BL_W'(BLINK_HALF - 1)) ? '0 : (bcnt_q + 1'b1);
    end
  end

  assign blink_out = blink_q;

endmodule
